axis_hdr_insert_sched: RTL
==========================

// Module: axis_hdr_insert_sched
// PURPOSE
//  Packet-level round-robin scheduler sharing one axi_stream_insert_header instance between N sources.
//  Each source presents a header (data/keep/byte count) plus its payload AXI-Stream.
//  Grants one source per packet, forwards its header to the inserter's header port, then routes its payload.
//  Holds the grant until the inserter reports packet completion, so the inserter only ever sees one packet in flight.
// PARAMETERS
//  N_SRC        4   number of requesting sources (2..8)
//  DATA_WD      32  payload/header data width
//  DATA_BYTE_WD 4   keep width, DATA_WD/8
//  BYTE_CNT_WD  3   header byte-count width
//  ID_WD        2   grant index width, clog2(N_SRC)
// PORTS
//  clk           in  1                      clock
//  rst_n         in  1                      synchronous active-low reset
//  s_hdr_valid   in  N_SRC                  per-source header valid
//  s_hdr_data    in  N_SRC*DATA_WD          per-source header data, source i at [i*DATA_WD +: DATA_WD]
//  s_hdr_keep    in  N_SRC*DATA_BYTE_WD     per-source header keep
//  s_hdr_cnt     in  N_SRC*BYTE_CNT_WD      per-source header byte count
//  s_hdr_ready   out N_SRC                  per-source header ready
//  s_valid       in  N_SRC                  per-source payload valid
//  s_data        in  N_SRC*DATA_WD          per-source payload data
//  s_keep        in  N_SRC*DATA_BYTE_WD     per-source payload keep
//  s_last        in  N_SRC                  per-source payload last
//  s_ready       out N_SRC                  per-source payload ready
//  m_hdr_valid   out 1                      to inserter valid_insert
//  m_hdr_data    out DATA_WD                to inserter data_insert
//  m_hdr_keep    out DATA_BYTE_WD           to inserter keep_insert
//  m_hdr_cnt     out BYTE_CNT_WD            to inserter byte_insert_cnt
//  m_hdr_ready   in  1                      from inserter ready_insert
//  m_valid/m_data/m_keep/m_last out         to inserter valid_in/data_in/keep_in/last_in
//  m_ready       in  1                      from inserter ready_in
//  pkt_done      in  1                      inserter last_out & ready_out, one-cycle pulse
//  grant_id      out ID_WD                  currently/last granted source
//  busy          out 1                      high in any state except IDLE
//  cnt_err       out 1                      one-cycle pulse: captured header cnt > DATA_BYTE_WD
//  pkt_count     out 16                     completed packets, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, m_hdr_valid 0, m_hdr_data/keep/cnt 0, grant_id 0, busy 0, cnt_err 0, pkt_count 0.
//  Reset: all s_*ready 0. Reset mid-packet abandons the packet, with no flush.
//  FSM IDLE -> HDR -> PAYLOAD -> DRAIN -> IDLE.
//  IDLE: req = s_hdr_valid. Winner is the first set bit at or after the pointer, searching cyclically.
//  IDLE: s_hdr_ready[winner] = 1 combinationally in the same cycle; header captured into m_hdr_* regs.
//  IDLE: grant_id <= winner; next state HDR. With no request, stay in IDLE.
//  HDR: m_hdr_valid = 1 and m_hdr_* held stable until m_hdr_valid & m_hdr_ready; then m_hdr_valid <= 0, go to PAYLOAD.
//  PAYLOAD: m_valid/data/keep/last = s_*[grant_id] combinationally, zero latency.
//  PAYLOAD: s_ready[grant_id] = m_ready; all other s_ready = 0.
//  PAYLOAD: on m_valid & m_ready & m_last, go to DRAIN. In the same cycle m_valid is masked 0 from the next cycle.
//  DRAIN: payload and header inputs blocked. On pkt_done go to IDLE, pointer <= grant_id+1 (mod N_SRC), pkt_count++.
//  pkt_done outside DRAIN is ignored and not counted.
//  Header cnt > DATA_BYTE_WD: clamp to DATA_BYTE_WD in the capture reg and pulse cnt_err the cycle after capture.
//  Simultaneous requests: the round-robin order guarantees each requester waits at most N_SRC-1 packets.
//  s_hdr_valid of a non-granted source may drop; no grant is made to a dropped request.
//  Payload beats arriving before the grant are stalled (s_ready 0) and are never dropped.
//  Minimum packet-to-packet gap: 1 IDLE cycle after pkt_done.
// STRUCTURE
//  Shared package axis_hdr_pkg contains: sched_state_e enum {IDLE,HDR,PAYLOAD,DRAIN}, and function rr_pick(req,ptr) used by the arbiter and TB model.
//  Sub-module rr_arbiter (N, req, ptr -> grant index, any_req), purely combinational.
//  The top module holds the FSM, header capture regs, payload mux and counters.
// TESTING
//  Single source 0: hdr 32'hAABBCCDD cnt 2, payload of 3 beats -> 1 header handshake, 3 beats forwarded, pkt_done -> pkt_count 1.
//  All 4 sources request together from reset -> grant order 0,1,2,3,0; each grant waits for the prior pkt_done.
//  m_hdr_ready held 0 for 5 cycles -> m_hdr_* stable, no payload forwarded, s_ready all 0.
//  m_ready toggling 1010 during a 4-beat payload -> the beat sequence is forwarded intact, and s_ready mirrors m_ready only for grant_id.
//  hdr cnt 3'd7 -> m_hdr_cnt 4, cnt_err pulse for 1 cycle; pkt_done pulse while in PAYLOAD -> ignored.
//  rst_n low while in PAYLOAD -> next cycle busy 0, m_hdr_valid 0, all ready 0, pointer 0.

Source files
------------

// File: rtl/axis_hdr_insert_sched_pkg.sv
// -----------------------------------------------------------------------------
// axis_hdr_pkg
//   Shared definitions for the header-insert scheduler:
//     sched_state_e : scheduler FSM states
//     RR_MAX        : widest request vector rr_pick accepts
//     rr_pick       : cyclic first-set-bit search starting at a pointer
// -----------------------------------------------------------------------------
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DRAIN
  } sched_state_e;

  localparam int RR_MAX = 8;

  // Returns the index of the first set bit of req at or after ptr, wrapping
  // modulo n. Returns 0 when req is empty; callers qualify with |req.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int                n);
    logic [2:0] pick;
    logic       found;
    logic [2:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if ((k < n) && !found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_hdr_insert_sched_if.sv
// -----------------------------------------------------------------------------
// axis_hdr_insert_sched_if
//   Header + payload AXI-Stream bundle. NL lanes are packed side by side;
//   lane i occupies [i*W +: W] of each wide field.
//   Header  : hdr_valid, hdr_data, hdr_keep, hdr_cnt  (master -> slave)
//             hdr_ready                               (slave  -> master)
//   Payload : valid, data, keep, last                 (master -> slave)
//             ready                                   (slave  -> master)
//   master modport: the side producing data; slave modport: the consumer.
// -----------------------------------------------------------------------------
interface axis_hdr_insert_sched_if #(
  parameter int NL           = 1,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = 4,
  parameter int BYTE_CNT_WD  = 3
);

  logic [NL-1:0]              hdr_valid;
  logic [NL*DATA_WD-1:0]      hdr_data;
  logic [NL*DATA_BYTE_WD-1:0] hdr_keep;
  logic [NL*BYTE_CNT_WD-1:0]  hdr_cnt;
  logic [NL-1:0]              hdr_ready;

  logic [NL-1:0]              valid;
  logic [NL*DATA_WD-1:0]      data;
  logic [NL*DATA_BYTE_WD-1:0] keep;
  logic [NL-1:0]              last;
  logic [NL-1:0]              ready;

  modport master (
    output hdr_valid, hdr_data, hdr_keep, hdr_cnt,
    output valid, data, keep, last,
    input  hdr_ready, ready
  );

  modport slave (
    input  hdr_valid, hdr_data, hdr_keep, hdr_cnt,
    input  valid, data, keep, last,
    output hdr_ready, ready
  );

endinterface

// File: rtl/axis_hdr_insert_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick.
//   req     in  N      request vector
//   ptr     in  ID_WD  highest-priority index for this decision
//   grant   out ID_WD  first requester at or after ptr (cyclic)
//   any_req out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import axis_hdr_pkg::*;
#(
  parameter int N     = 4,
  parameter int ID_WD = 2
) (
  input  logic [N-1:0]     req,
  input  logic [ID_WD-1:0] ptr,
  output logic [ID_WD-1:0] grant,
  output logic             any_req
);

  logic [RR_MAX-1:0] req_ext;
  logic [2:0]        ptr_ext;
  logic [2:0]        pick;

  assign req_ext = RR_MAX'(req);
  assign ptr_ext = 3'(ptr);
  assign pick    = rr_pick(req_ext, ptr_ext, N);
  assign grant   = ID_WD'(pick);
  assign any_req = |req;

endmodule

// File: rtl/axis_hdr_insert_sched.sv
// -----------------------------------------------------------------------------
// axis_hdr_insert_sched
//   Packet-level round-robin scheduler that shares one header inserter among
//   N_SRC sources. A source is granted for a whole packet: its header is
//   captured and offered to the inserter, its payload is then routed through,
//   and the grant is held until the inserter signals packet completion.
//
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   s          slave  per-source header + payload streams (NL = N_SRC)
//   m          master header + payload toward the inserter (NL = 1)
//   pkt_done   in   inserter completion pulse (only honoured in DRAIN)
//   grant_id   out  current / last granted source
//   busy       out  FSM not in IDLE
//   cnt_err    out  one-cycle pulse after capturing an oversized byte count
//   pkt_count  out  completed packets, free-running 16-bit wrap
// -----------------------------------------------------------------------------
module axis_hdr_insert_sched
  import axis_hdr_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = 4,
  parameter int BYTE_CNT_WD  = 3,
  parameter int ID_WD        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axis_hdr_insert_sched_if.slave   s,
  axis_hdr_insert_sched_if.master  m,
  input  logic                     pkt_done,
  output logic [ID_WD-1:0]         grant_id,
  output logic                     busy,
  output logic                     cnt_err,
  output logic [15:0]              pkt_count
);

  localparam logic [BYTE_CNT_WD-1:0] CNT_MAX = BYTE_CNT_WD'(DATA_BYTE_WD);

  // Byte count can never exceed one data word of bytes.
  function automatic logic [BYTE_CNT_WD-1:0] sat_cnt(input logic [BYTE_CNT_WD-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  function automatic logic [ID_WD-1:0] wrap_inc(input logic [ID_WD-1:0] id);
    return (int'(id) == N_SRC - 1) ? '0 : id + ID_WD'(1);
  endfunction

  sched_state_e state_q, state_d;

  logic [ID_WD-1:0]        winner;
  logic                    any_req;
  logic [ID_WD-1:0]        ptr_q;
  logic [ID_WD-1:0]        grant_q;
  logic                    cnt_err_q;
  logic [15:0]             pkt_count_q;

  logic                    hdr_vld_p1;
  logic [DATA_WD-1:0]      hdr_data_p1;
  logic [DATA_BYTE_WD-1:0] hdr_keep_p1;
  logic [BYTE_CNT_WD-1:0]  hdr_cnt_p1;

  logic                    hdr_take;
  logic                    hdr_acc;
  logic                    done_acc;
  logic                    pay_vld;
  logic [N_SRC-1:0]        hdr_rdy_c;
  logic [N_SRC-1:0]        pay_rdy_c;

  logic [DATA_WD-1:0]      sel_hdr_data;
  logic [DATA_BYTE_WD-1:0] sel_hdr_keep;
  logic [BYTE_CNT_WD-1:0]  sel_hdr_cnt;

  rr_arbiter #(
    .N     (N_SRC),
    .ID_WD (ID_WD)
  ) u_arb (
    .req     (s.hdr_valid),
    .ptr     (ptr_q),
    .grant   (winner),
    .any_req (any_req)
  );

  assign sel_hdr_data = s.hdr_data[winner*DATA_WD +: DATA_WD];
  assign sel_hdr_keep = s.hdr_keep[winner*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign sel_hdr_cnt  = s.hdr_cnt[winner*BYTE_CNT_WD +: BYTE_CNT_WD];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hdr_take  = 1'b0;
    hdr_acc   = 1'b0;
    done_acc  = 1'b0;
    pay_vld   = 1'b0;
    hdr_rdy_c = '0;
    pay_rdy_c = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          hdr_take          = 1'b1;
          hdr_rdy_c[winner] = 1'b1;
          state_d           = HDR;
        end
      end
      HDR: begin
        if (hdr_vld_p1 && m.hdr_ready[0]) begin
          hdr_acc = 1'b1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        pay_vld            = s.valid[grant_q];
        pay_rdy_c[grant_q] = m.ready[0];
        if (pay_vld && m.ready[0] && s.last[grant_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (pkt_done) begin
          done_acc = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Hold every handshake closed while reset is asserted.
    if (!rst_n) begin
      hdr_rdy_c = '0;
      pay_rdy_c = '0;
      pay_vld   = 1'b0;
    end
  end

  // Stage p1: captured header presented to the inserter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_vld_p1  <= 1'b0;
      hdr_data_p1 <= '0;
      hdr_keep_p1 <= '0;
      hdr_cnt_p1  <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_err_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      cnt_err_q <= 1'b0;
      if (hdr_take) begin
        hdr_vld_p1  <= 1'b1;
        hdr_data_p1 <= sel_hdr_data;
        hdr_keep_p1 <= sel_hdr_keep;
        hdr_cnt_p1  <= sat_cnt(sel_hdr_cnt);
        cnt_err_q   <= (sel_hdr_cnt > CNT_MAX);
        grant_q     <= winner;
      end
      if (hdr_acc) hdr_vld_p1 <= 1'b0;
      if (done_acc) begin
        ptr_q       <= wrap_inc(grant_q);
        pkt_count_q <= pkt_count_q + 16'd1;
      end
    end
  end

  assign m.hdr_valid = hdr_vld_p1;
  assign m.hdr_data  = hdr_data_p1;
  assign m.hdr_keep  = hdr_keep_p1;
  assign m.hdr_cnt   = hdr_cnt_p1;

  // Payload is a zero-latency mux of the granted source.
  assign m.valid = pay_vld;
  assign m.data  = s.data[grant_q*DATA_WD +: DATA_WD];
  assign m.keep  = s.keep[grant_q*DATA_BYTE_WD +: DATA_BYTE_WD];
  assign m.last  = s.last[grant_q] & (state_q == PAYLOAD);

  assign s.hdr_ready = hdr_rdy_c;
  assign s.ready     = pay_rdy_c;

  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);
  assign cnt_err   = cnt_err_q;
  assign pkt_count = pkt_count_q;

endmodule
